// File: rtl/vend_sequencer_if.sv
// Panel, coin-sensor and changer signals of the vend sequencer, grouped so the
// controller and its environment connect through one bundle.
interface vend_sequencer_if;
  logic       coin_nickel;
  logic       coin_dime;
  logic       coin_quarter;
  logic       coin_dollar;
  logic       buy_req;
  logic       refund_req;
  logic       chg_nickel_out;
  logic       chg_dime_out;
  logic       chg_quarter_out;
  logic       chg_nickel;
  logic       chg_dime;
  logic       chg_quarter;
  logic       chg_dollar;
  logic       chg_vend;
  logic       chg_refunding;
  logic       coin_reject;
  logic       product_release;
  logic       busy;
  logic [7:0] credit;
  logic [7:0] change_returned;

  modport master (
    output coin_nickel, coin_dime, coin_quarter, coin_dollar,
    output buy_req, refund_req,
    output chg_nickel_out, chg_dime_out, chg_quarter_out,
    input  chg_nickel, chg_dime, chg_quarter, chg_dollar,
    input  chg_vend, chg_refunding, coin_reject, product_release, busy,
    input  credit, change_returned
  );

  modport slave (
    input  coin_nickel, coin_dime, coin_quarter, coin_dollar,
    input  buy_req, refund_req,
    input  chg_nickel_out, chg_dime_out, chg_quarter_out,
    output chg_nickel, chg_dime, chg_quarter, chg_dollar,
    output chg_vend, chg_refunding, coin_reject, product_release, busy,
    output credit, change_returned
  );
endinterface

// File: rtl/vend_sequencer.sv
// Coin acceptance front end and vend/refund sequencer for the coin changer.
// All outputs are registered; coin and button inputs are rising-edge detected.
module vend_sequencer #(
  parameter int PRICE      = 50,
  parameter int MAX_CREDIT = 150,
  parameter int QUIET      = 2
) (
  input logic             clock,
  input logic             reset,
  vend_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, VEND, SETTLE, REFUND} state_e;

  state_e     state_q;
  logic [3:0] coin_hist_q;
  logic       buy_hist_q;
  logic       refund_hist_q;
  logic [3:0] nick_cnt_q;
  logic [2:0] dime_cnt_q;
  logic [1:0] qtr_cnt_q;
  logic       dol_cnt_q;
  logic [3:0] quiet_q;
  logic [3:0] strobe_q;
  logic       vend_q;
  logic       refunding_q;
  logic       reject_q;
  logic       release_q;
  logic       busy_q;
  logic [7:0] credit_q;
  logic [7:0] change_q;

  logic [3:0] coin_raw;
  logic [3:0] coin_edge;
  logic       buy_edge;
  logic       refund_edge;
  logic       one_coin;
  logic [7:0] coin_val;
  logic       stack_full;
  logic [8:0] credit_sum;
  logic       leave_idle;
  logic       accept;
  logic       reject;
  logic [7:0] ret_val;
  logic [3:0] quiet_d;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  function automatic logic [7:0] sat_sub8(input logic [7:0] a, input logic [7:0] b);
    return (a >= b) ? (a - b) : 8'd0;
  endfunction

  always_comb begin
    coin_raw    = {bus.coin_dollar, bus.coin_quarter, bus.coin_dime, bus.coin_nickel};
    coin_edge   = coin_raw & ~coin_hist_q;
    buy_edge    = bus.buy_req & ~buy_hist_q;
    refund_edge = bus.refund_req & ~refund_hist_q;
    one_coin    = (coin_edge != 4'd0) && ((coin_edge & (coin_edge - 4'd1)) == 4'd0);
    coin_val    = 8'd0;
    stack_full  = 1'b1;
    case (coin_edge)
      4'b0001: begin coin_val = 8'd5;   stack_full = (nick_cnt_q == 4'd10); end
      4'b0010: begin coin_val = 8'd10;  stack_full = (dime_cnt_q == 3'd5);  end
      4'b0100: begin coin_val = 8'd25;  stack_full = (qtr_cnt_q == 2'd3);   end
      4'b1000: begin coin_val = 8'd100; stack_full = dol_cnt_q;             end
      default: ;
    endcase
    credit_sum = {1'b0, credit_q} + {1'b0, coin_val};
    // Coins arriving in the cycle the FSM leaves IDLE are refused so no strobe overlaps busy.
    leave_idle = (state_q == IDLE) &&
                 ((buy_edge && (credit_q >= 8'(PRICE))) || (refund_edge && (credit_q != 8'd0)));
    accept     = (state_q == IDLE) && !leave_idle && one_coin && !stack_full &&
                 (credit_sum <= 9'(MAX_CREDIT));
    reject     = (coin_edge != 4'd0) && !accept;
    ret_val    = (bus.chg_nickel_out  ? 8'd5  : 8'd0) +
                 (bus.chg_dime_out    ? 8'd10 : 8'd0) +
                 (bus.chg_quarter_out ? 8'd25 : 8'd0);
    quiet_d    = quiet_q + 4'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      coin_hist_q   <= 4'd0;
      buy_hist_q    <= 1'b0;
      refund_hist_q <= 1'b0;
      nick_cnt_q    <= 4'd0;
      dime_cnt_q    <= 3'd0;
      qtr_cnt_q     <= 2'd0;
      dol_cnt_q     <= 1'b0;
      quiet_q       <= 4'd0;
      strobe_q      <= 4'd0;
      vend_q        <= 1'b0;
      refunding_q   <= 1'b0;
      reject_q      <= 1'b0;
      release_q     <= 1'b0;
      busy_q        <= 1'b0;
      credit_q      <= 8'd0;
      change_q      <= 8'd0;
    end else begin
      coin_hist_q   <= coin_raw;
      buy_hist_q    <= bus.buy_req;
      refund_hist_q <= bus.refund_req;
      strobe_q      <= accept ? coin_edge : 4'd0;
      reject_q      <= reject;
      vend_q        <= 1'b0;
      release_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            credit_q <= credit_sum[7:0];
            case (coin_edge)
              4'b0001: nick_cnt_q <= nick_cnt_q + 4'd1;
              4'b0010: dime_cnt_q <= dime_cnt_q + 3'd1;
              4'b0100: qtr_cnt_q  <= qtr_cnt_q + 2'd1;
              default: dol_cnt_q  <= 1'b1;
            endcase
          end
          if (buy_edge && (credit_q >= 8'(PRICE))) begin
            state_q   <= VEND;
            vend_q    <= 1'b1;
            release_q <= 1'b1;
            busy_q    <= 1'b1;
          end else if (refund_edge && (credit_q != 8'd0)) begin
            state_q     <= REFUND;
            refunding_q <= 1'b1;
            busy_q      <= 1'b1;
            change_q    <= 8'd0;
            quiet_q     <= 4'd0;
          end
        end
        VEND: begin
          credit_q <= credit_q - 8'(PRICE);
          state_q  <= SETTLE;
        end
        SETTLE: begin
          if (credit_q != 8'd0) begin
            state_q     <= REFUND;
            refunding_q <= 1'b1;
            change_q    <= 8'd0;
            quiet_q     <= 4'd0;
          end else begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            nick_cnt_q <= 4'd0;
            dime_cnt_q <= 3'd0;
            qtr_cnt_q  <= 2'd0;
            dol_cnt_q  <= 1'b0;
          end
        end
        default: begin
          change_q <= sat_add8(change_q, ret_val);
          credit_q <= sat_sub8(credit_q, ret_val);
          if (ret_val != 8'd0) begin
            quiet_q <= 4'd0;
          end else if (quiet_d == 4'(QUIET)) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            refunding_q <= 1'b0;
            quiet_q     <= 4'd0;
            credit_q    <= 8'd0;
            nick_cnt_q  <= 4'd0;
            dime_cnt_q  <= 3'd0;
            qtr_cnt_q   <= 2'd0;
            dol_cnt_q   <= 1'b0;
          end else begin
            quiet_q <= quiet_d;
          end
        end
      endcase
    end
  end

  assign bus.chg_nickel      = strobe_q[0];
  assign bus.chg_dime        = strobe_q[1];
  assign bus.chg_quarter     = strobe_q[2];
  assign bus.chg_dollar      = strobe_q[3];
  assign bus.chg_vend        = vend_q;
  assign bus.chg_refunding   = refunding_q;
  assign bus.coin_reject     = reject_q;
  assign bus.product_release = release_q;
  assign bus.busy            = busy_q;
  assign bus.credit          = credit_q;
  assign bus.change_returned = change_q;

endmodule
